// File: rtl/display_sched_pkg.sv
// Shared types and helpers for the display scheduler: FSM state encoding,
// index-width helper and the round-robin pick function.
package display_sched_pkg;

  localparam int unsigned MaxSrc  = 8;
  localparam int unsigned MaxIdxW = 3;

  typedef enum logic [1:0] {
    StShowAuto,
    StBlank,
    StShowHold
  } sched_state_t;

  typedef struct packed {
    logic               valid;
    logic [MaxIdxW-1:0] idx;
  } pick_t;

  // Width of a source index; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // First asserted request found searching upward from last+1, wrapping at num_src.
  function automatic pick_t rr_pick(input logic [MaxSrc-1:0]  req,
                                    input logic [MaxIdxW-1:0] last,
                                    input int unsigned        num_src);
    pick_t       p;
    int unsigned cand;
    p = '0;
    for (int unsigned i = 1; i <= MaxSrc; i++) begin
      cand = (32'(last) + i) % num_src;
      if (i <= num_src && !p.valid && req[cand[MaxIdxW-1:0]]) begin
        p.valid = 1'b1;
        p.idx   = cand[MaxIdxW-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/sched_arbiter.sv
// Picks which requesting source gets exclusive display ownership.
// Default build: round-robin starting after the last granted source.
// With DISPLAY_SCHED_PRIORITY_EN defined: lowest asserted index always wins.
module sched_arbiter
  import display_sched_pkg::*;
#(
  parameter int unsigned NUM_SRC = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_SRC-1:0]           req,
  input  logic                         update,
  input  logic [idx_w(NUM_SRC)-1:0]    grant_idx,
  output logic                         pick_valid,
  output logic [idx_w(NUM_SRC)-1:0]    pick_idx
);

  localparam int unsigned IdxW = idx_w(NUM_SRC);

  logic [MaxSrc-1:0] req_ext;
  pick_t             pick;

  // Zero-extend the request vector to the package's fixed width.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_SRC-1:0]   = req;
  end

`ifdef DISPLAY_SCHED_PRIORITY_EN
  logic unused_inputs;
  assign unused_inputs = ^{clk, reset, update, grant_idx};

  // Fixed priority: scan downward so the lowest asserted index is kept.
  always_comb begin
    pick = '0;
    for (int i = MaxSrc - 1; i >= 0; i--) begin
      if (req_ext[i]) begin
        pick.valid = 1'b1;
        pick.idx   = i[MaxIdxW-1:0];
      end
    end
  end
`else
  logic [IdxW-1:0] last_granted;

  // Remember the most recent grant; reset value makes source 0 win first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_granted <= IdxW'(NUM_SRC - 1);
    end else if (update) begin
      last_granted <= grant_idx;
    end
  end

  // Round-robin search starting just after the last grant.
  always_comb begin
    pick = rr_pick(req_ext, MaxIdxW'(last_granted), NUM_SRC);
  end
`endif

  assign pick_valid = pick.valid;
  assign pick_idx   = pick.idx[IdxW-1:0];

endmodule

// File: rtl/display_scheduler.sv
// Time-multiplexes NUM_SRC digit sources onto one seven-segment driver.
// Sources rotate on a dwell timer or on next_btn, separated by a blank gap;
// a source may take exclusive ownership through src_req/src_gnt.
// Build option: DISPLAY_SCHED_PRIORITY_EN selects fixed-priority arbitration.
module display_scheduler
  import display_sched_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 3,
  parameter int unsigned NUM_SEGMENTS = 4,
  parameter int unsigned DWELL_CYCLES = 100_000_000,
  parameter int unsigned BLANK_CYCLES = 1_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SEGMENTS*4-1:0]   src_encoded     [NUM_SRC],
  input  logic [NUM_SEGMENTS-1:0]     src_digit_point [NUM_SRC],
  input  logic [NUM_SRC-1:0]          src_req,
  output logic [NUM_SRC-1:0]          src_gnt,
  input  logic                        next_btn,
  input  logic                        auto_en,
  output logic [NUM_SEGMENTS*4-1:0]   out_encoded,
  output logic [NUM_SEGMENTS-1:0]     out_digit_point,
  output logic                        out_blank,
  output logic [idx_w(NUM_SRC)-1:0]   active_idx
);

  localparam int unsigned IdxW = idx_w(NUM_SRC);

  sched_state_t    state;
  logic [31:0]     timer;
  logic            hold_pending;
  logic [IdxW-1:0] idx_inc;
  logic            blank_done;
  logic            arb_update;
  logic            pick_valid;
  logic [IdxW-1:0] pick_idx;

  assign idx_inc    = (active_idx == IdxW'(NUM_SRC - 1)) ? '0 : active_idx + 1'b1;
  assign blank_done = (timer == BLANK_CYCLES - 1);
  // last_granted moves only when a grant is actually issued at blank exit.
  assign arb_update = (state == StBlank) && blank_done && hold_pending && src_req[active_idx];

  sched_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_arbiter (
    .clk        (clk),
    .reset      (reset),
    .req        (src_req),
    .update     (arb_update),
    .grant_idx  (active_idx),
    .pick_valid (pick_valid),
    .pick_idx   (pick_idx)
  );

  // Scheduler FSM; display outputs default to the current source and are
  // overridden to blank whenever the next state is StBlank.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= StShowAuto;
      active_idx      <= '0;
      timer           <= '0;
      hold_pending    <= 1'b0;
      src_gnt         <= '0;
      out_blank       <= 1'b0;
      out_encoded     <= '0;
      out_digit_point <= '0;
    end else begin
      out_encoded     <= src_encoded[active_idx];
      out_digit_point <= src_digit_point[active_idx];
      out_blank       <= 1'b0;
      unique case (state)
        StShowAuto: begin
          if (pick_valid || next_btn || (auto_en && timer == DWELL_CYCLES - 1)) begin
            active_idx      <= pick_valid ? pick_idx : idx_inc;
            hold_pending    <= pick_valid;
            state           <= StBlank;
            timer           <= '0;
            out_blank       <= 1'b1;
            out_encoded     <= '0;
            out_digit_point <= '0;
          end else if (auto_en) begin
            timer <= timer + 32'd1;
          end
        end
        StBlank: begin
          if (blank_done) begin
            timer        <= '0;
            hold_pending <= 1'b0;
            // A requester that let go during the gap never receives a grant.
            if (hold_pending && src_req[active_idx]) begin
              state   <= StShowHold;
              src_gnt <= NUM_SRC'(1) << active_idx;
            end else begin
              state <= StShowAuto;
            end
          end else begin
            timer           <= timer + 32'd1;
            out_blank       <= 1'b1;
            out_encoded     <= '0;
            out_digit_point <= '0;
          end
        end
        StShowHold: begin
          if (!src_req[active_idx]) begin
            src_gnt         <= '0;
            active_idx      <= pick_valid ? pick_idx : idx_inc;
            hold_pending    <= pick_valid;
            state           <= StBlank;
            timer           <= '0;
            out_blank       <= 1'b1;
            out_encoded     <= '0;
            out_digit_point <= '0;
          end
        end
        default: state <= StShowAuto;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler (3 sources, dwell 8, blank 2).
// The driver pushes the expected display state for each cycle; a monitor
// on the falling edge pops and compares entries tagged with that cycle.
module tb_display_scheduler;

  localparam int unsigned NumSrc = 3;
  localparam int unsigned NumSeg = 4;

`ifdef DISPLAY_SCHED_PRIORITY_EN
  localparam int PrioWin = 0;
`else
  localparam int PrioWin = 2;
`endif

  typedef struct {
    int          cyc;
    string       name;
    logic        blank;
    logic [1:0]  idx;
    logic [2:0]  gnt;
    logic [15:0] enc;
    logic [3:0]  dp;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic [15:0]        src_encoded     [NumSrc];
  logic [3:0]         src_digit_point [NumSrc];
  logic [2:0]         src_req;
  logic [2:0]         src_gnt;
  logic               next_btn;
  logic               auto_en;
  logic [15:0]        out_encoded;
  logic [3:0]         out_digit_point;
  logic               out_blank;
  logic [1:0]         active_idx;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  display_scheduler #(
    .NUM_SRC      (NumSrc),
    .NUM_SEGMENTS (NumSeg),
    .DWELL_CYCLES (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .src_encoded     (src_encoded),
    .src_digit_point (src_digit_point),
    .src_req         (src_req),
    .src_gnt         (src_gnt),
    .next_btn        (next_btn),
    .auto_en         (auto_en),
    .out_encoded     (out_encoded),
    .out_digit_point (out_digit_point),
    .out_blank       (out_blank),
    .active_idx      (active_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      n_tests++;
      if (mon_e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not checked until %0d",
                 mon_e.name, mon_e.cyc, cyc);
      end else if (out_blank !== mon_e.blank || active_idx !== mon_e.idx ||
                   src_gnt !== mon_e.gnt || out_encoded !== mon_e.enc ||
                   out_digit_point !== mon_e.dp) begin
        n_fail++;
        $display("FAIL %s @%0d: got blank=%b idx=%0d gnt=%b enc=%h dp=%h, want blank=%b idx=%0d gnt=%b enc=%h dp=%h",
                 mon_e.name, cyc, out_blank, active_idx, src_gnt, out_encoded, out_digit_point,
                 mon_e.blank, mon_e.idx, mon_e.gnt, mon_e.enc, mon_e.dp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance n clocks, pushing the expected display state after each edge.
  task automatic run(input int n, input string name, input logic blank, input int idx,
                     input logic [2:0] gnt, input logic shown);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      step();
      e.cyc   = cyc;
      e.name  = name;
      e.blank = blank;
      e.idx   = idx[1:0];
      e.gnt   = gnt;
      e.enc   = shown ? src_encoded[idx] : 16'h0;
      e.dp    = shown ? src_digit_point[idx] : 4'h0;
      sb_q.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] gw;
    int         nw;
    src_encoded[0]     = 16'h1234;
    src_encoded[1]     = 16'h5678;
    src_encoded[2]     = 16'h9abc;
    src_digit_point[0] = 4'h1;
    src_digit_point[1] = 4'h2;
    src_digit_point[2] = 4'h4;
    reset    = 1'b1;
    src_req  = 3'b000;
    next_btn = 1'b0;
    auto_en  = 1'b0;
    run(2, "reset", 1'b0, 0, 3'b000, 1'b0);

    // Timed rotation 0 -> 1 -> 2 -> 0 with blank gaps.
    reset   = 1'b0;
    auto_en = 1'b1;
    run(7, "auto0", 1'b0, 0, 3'b000, 1'b1);
    run(2, "blank01", 1'b1, 1, 3'b000, 1'b0);
    run(8, "auto1", 1'b0, 1, 3'b000, 1'b1);
    run(2, "blank12", 1'b1, 2, 3'b000, 1'b0);
    run(8, "auto2", 1'b0, 2, 3'b000, 1'b1);
    run(2, "blank20", 1'b1, 0, 3'b000, 1'b0);
    run(1, "auto0_wrap", 1'b0, 0, 3'b000, 1'b1);

    // Manual stepping; a held button is ignored during the gap.
    auto_en  = 1'b0;
    next_btn = 1'b1;
    run(1, "btn01", 1'b1, 1, 3'b000, 1'b0);
    next_btn = 1'b0;
    run(1, "btn01", 1'b1, 1, 3'b000, 1'b0);
    run(3, "man1", 1'b0, 1, 3'b000, 1'b1);
    next_btn = 1'b1;
    run(2, "btn12_held", 1'b1, 2, 3'b000, 1'b0);
    next_btn = 1'b0;
    run(3, "man2", 1'b0, 2, 3'b000, 1'b1);
    next_btn = 1'b1;
    run(1, "btn20", 1'b1, 0, 3'b000, 1'b0);
    next_btn = 1'b0;
    run(1, "btn20", 1'b1, 0, 3'b000, 1'b0);
    run(20, "man0_stay", 1'b0, 0, 3'b000, 1'b1);

    // Exclusive hold handed from source 1 to source 2, then released.
    src_req = 3'b110;
    run(2, "req1_blank", 1'b1, 1, 3'b000, 1'b0);
    run(4, "hold1", 1'b0, 1, 3'b010, 1'b1);
    src_req = 3'b100;
    run(2, "drop1_blank", 1'b1, 2, 3'b000, 1'b0);
    run(3, "hold2", 1'b0, 2, 3'b100, 1'b1);
    src_req = 3'b000;
    run(2, "drop2_blank", 1'b1, 0, 3'b000, 1'b0);
    run(3, "auto0_after_hold", 1'b0, 0, 3'b000, 1'b1);

    // Button and request together: request wins, no extra advance.
    next_btn = 1'b1;
    src_req  = 3'b001;
    run(1, "btnreq_blank", 1'b1, 0, 3'b000, 1'b0);
    next_btn = 1'b0;
    run(1, "btnreq_blank", 1'b1, 0, 3'b000, 1'b0);
    run(3, "hold0", 1'b0, 0, 3'b001, 1'b1);
    src_req = 3'b000;
    run(2, "rel0_blank", 1'b1, 1, 3'b000, 1'b0);
    run(2, "auto1_after_rel", 1'b0, 1, 3'b000, 1'b1);

    // Requester drops before the gap ends: no grant.
    src_req = 3'b100;
    run(1, "pend2_blank", 1'b1, 2, 3'b000, 1'b0);
    src_req = 3'b000;
    run(1, "pend2_blank", 1'b1, 2, 3'b000, 1'b0);
    run(3, "pend2_nogrant", 1'b0, 2, 3'b000, 1'b1);

    // Request seen only mid-gap is never sampled.
    next_btn = 1'b1;
    run(1, "midreq_blank", 1'b1, 0, 3'b000, 1'b0);
    next_btn = 1'b0;
    src_req  = 3'b100;
    run(1, "midreq_blank", 1'b1, 0, 3'b000, 1'b0);
    src_req  = 3'b000;
    run(3, "midreq_nogrant", 1'b0, 0, 3'b000, 1'b1);

    // Reset in the middle of a hold, with the request still asserted.
    src_req = 3'b010;
    run(2, "req1b_blank", 1'b1, 1, 3'b000, 1'b0);
    run(2, "hold1b", 1'b0, 1, 3'b010, 1'b1);
    reset = 1'b1;
    run(1, "reset_in_hold", 1'b0, 0, 3'b000, 1'b0);
    reset   = 1'b0;
    src_req = 3'b000;
    run(2, "post_reset", 1'b0, 0, 3'b000, 1'b1);

    // Arbitration policy with req=101 twice: source 0 first, then policy winner.
    src_req = 3'b101;
    run(2, "arb_blank0", 1'b1, 0, 3'b000, 1'b0);
    run(2, "arb_hold0", 1'b0, 0, 3'b001, 1'b1);
    src_req = 3'b000;
    run(2, "arb_rel0", 1'b1, 1, 3'b000, 1'b0);
    run(1, "arb_auto1", 1'b0, 1, 3'b000, 1'b1);
    src_req = 3'b101;
    gw = 3'b001 << PrioWin;
    nw = (PrioWin + 1) % 3;
    run(2, "arb_blank_w", 1'b1, PrioWin, 3'b000, 1'b0);
    run(2, "arb_hold_w", 1'b0, PrioWin, gw, 1'b1);
    src_req = 3'b000;
    run(2, "arb_rel_w", 1'b1, nw, 3'b000, 1'b0);
    run(1, "arb_auto_end", 1'b0, nw, 3'b000, 1'b1);

    // Let the monitor drain, bounded.
    for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Shares one seven_segment driver between NUM_SRC counter sources.
- Sources are shown in round-robin time slices, with a blank gap between slices.
- The button can step to the next source manually.
- A source can request exclusive display ownership through a req/gnt handshake.
- Sits between the counter instances and a single seven_segment instance, driven by the cleaned button_down pulse.

Parameters:
- NUM_SRC, 3, number of counter sources (2..8).
- NUM_SEGMENTS, 4, digits per source/display.
- DWELL_CYCLES, 100_000_000, clocks each source is shown in auto rotation (>=2).
- BLANK_CYCLES, 1_000_000, clocks of blank gap between any two slices (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- src_encoded  in  NUM_SRC x NUM_SEGMENTS x 4  per-source digit nibbles (unpacked by source, packed by digit).
- src_digit_point  in  NUM_SRC x NUM_SEGMENTS  per-source decimal points.
- src_req  in  NUM_SRC  level request for exclusive display.
- src_gnt  out  NUM_SRC  one-hot grant; all zero when no hold is active.
- next_btn  in  1  single-cycle pulse (button_down); advance to the next source.
- auto_en  in  1  1 = timed rotation enabled; 0 = advance only on next_btn.
- out_encoded  out  NUM_SEGMENTS x 4  to seven_segment encoded.
- out_digit_point  out  NUM_SEGMENTS  to seven_segment digit_point.
- out_blank  out  1  high during the blank gap.
- active_idx  out  $clog2(NUM_SRC)  source currently or next shown.

Behaviour:
- Reset values: state=SHOW_AUTO, active_idx=0, timer=0, src_gnt=0, out_blank=0, out_encoded=0, out_digit_point=0. Reset wins over all inputs in any state.
- Outputs are registered: out_encoded/out_digit_point = source[active_idx] delayed 1 clk. While out_blank=1 both are 0.
- States: SHOW_AUTO, BLANK, SHOW_HOLD.
- SHOW_AUTO, rules evaluated in this priority:
  - any src_req -> pick winner, set active_idx=winner, go to BLANK with hold_pending=1.
  - else next_btn -> active_idx=(idx+1) mod NUM_SRC, go to BLANK.
  - else auto_en and timer==DWELL_CYCLES-1 -> advance as for next_btn.
  - else timer++ when auto_en=1; timer holds when auto_en=0.
- BLANK:
  - out_blank=1 from the cycle after entry.
  - Lasts exactly BLANK_CYCLES clocks, then goes to SHOW_HOLD if hold_pending, else SHOW_AUTO. timer clears on entry to either.
  - next_btn is ignored; src_req changes are sampled only at exit.
  - If the pending requester dropped req by exit, go to SHOW_AUTO (no grant ever issued).
- SHOW_HOLD:
  - src_gnt[active_idx]=1 (registered, asserted the cycle SHOW_HOLD is entered).
  - next_btn and timer are ignored.
  - When src_req[active_idx] falls: gnt deasserts next cycle. Then pick a new winner among the remaining reqs -> BLANK with hold_pending; none -> BLANK, with active_idx=(idx+1) mod NUM_SRC.
- Round-robin pick: search starts at (last_granted+1) mod NUM_SRC, wrapping. last_granted resets to NUM_SRC-1, so src 0 wins first.
- Wrap: active_idx NUM_SRC-1 -> 0.
- Simultaneous next_btn and req: req wins; the button is dropped.
- src_gnt is never asserted during BLANK or SHOW_AUTO; at most one bit is set.

Optional Feature:
- Macro: DISPLAY_SCHED_PRIORITY_EN.
- Defined: fixed-priority pick, lowest asserted index wins; last_granted is unused.
- Undefined: round-robin as above.

Decomposition:
- Package display_sched_pkg: sched_state_t enum {SHOW_AUTO, BLANK, SHOW_HOLD}; IDX_W localparam helper; function rr_pick(req, last) returning {valid, idx}.
- Sub-module sched_arbiter: combinational pick plus registered last_granted; the priority macro is handled inside it.

Test Plan (NUM_SRC=3, NUM_SEGMENTS=4, DWELL_CYCLES=8, BLANK_CYCLES=2):
- Reset then auto_en=1, no req -> idx 0 shown for 8 clks, out_blank=1 for 2 clks, then idx 1, 2, 0; out_encoded matches source after 1 clk.
- auto_en=0, next_btn pulse at idx 2 -> blank for 2 clks, idx 0 shown. With no further pulses it stays indefinitely.
- src_req=3'b110 from idx 0 -> blank, gnt=3'b010 held while req[1]=1. Drop req[1] -> gnt=0, blank, gnt=3'b100.
- next_btn coincident with src_req[0] rising -> grant path taken, active_idx=0, no extra advance.
- req[2] pulses during BLANK only -> no grant, returns to SHOW_AUTO.
- Reset asserted mid-SHOW_HOLD -> next clk gnt=0, idx=0, out_blank=0, outputs 0; with DISPLAY_SCHED_PRIORITY_EN, req=3'b101 repeatedly -> src 0 always wins.
